// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; one bit per clock.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  always_comb begin
    rs_neg = op_i[0] & rs_i[WIDTH-1];
    rt_neg = op_i[0] & rt_i[WIDTH-1];
    rs_mag = rs_neg ? (~rs_i + 1'b1) : rs_i;
    rt_mag = rt_neg ? (~rt_i + 1'b1) : rt_i;

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, mcand_q};
    div_ok    = ~div_diff[WIDTH];
    if (is_div_q) begin
      acc_step = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ok};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      // Divide by zero: the remainder naturally equals the dividend; only LO needs forcing.
      fix_hi = rem_fix;
      fix_lo = (mcand_q == '0) ? '1 : quot_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i && !flush_i) begin
            state_q   <= StRun;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= {{WIDTH{1'b0}}, rs_mag};
            mcand_q   <= rt_mag;
            is_div_q  <= op_i[1];
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
          end
        end
        StRun: begin
          if (flush_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q <= StFix;
              cnt_q   <= '0;
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!flush_i) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit, checked against a 64-bit arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [W-1:0]  rs_i = '0;
  logic [W-1:0]  rt_i = '0;
  logic          flush_i = 1'b0;
  logic          hi_we_i = 1'b0;
  logic          lo_we_i = 1'b0;
  logic [W-1:0]  wdata_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int n_asserts = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .flush_i (flush_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  // Reference: {HI, LO} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint p;
    int     sa;
    int     sb;
    int     q;
    int     r;
    sa = a;
    sb = b;
    case (op)
      2'b00: model = {32'b0, a} * {32'b0, b};
      2'b01: begin
        p = longint'(sa) * longint'(sb);
        model = p;
      end
      2'b10: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r, q};
        end
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the start is sampled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i = op;
    rs_i = a;
    rt_i = b;
    @(negedge clk);
    start_i = 1'b0;
    rs_i = $urandom;
    rt_i = $urandom;
    op_i = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!done_o && cyc < 200) begin
      if (busy_o) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    int cyc;
    int bcnt;
    issue(op, a, b);
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(W + 1));
    check({tag, "_hilo"}, {hi_o, lo_o}, model(op, a, b));
  endtask

  initial begin
    int cyc;
    int bcnt;
    int dcnt;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_hi", 64'(hi_o), 64'h0);
    check("reset_lo", 64'(lo_o), 64'h0);
    check("reset_busy", 64'(busy_o), 64'h0);
    check("reset_done", 64'(done_o), 64'h0);

    hi_we_i = 1'b1;
    wdata_i = 32'h1234_5678;
    @(negedge clk);
    hi_we_i = 1'b0;
    check("mthi", 64'(hi_o), 64'h1234_5678);

    run_check("mult_neg1x2", 2'b01, 32'hFFFF_FFFF, 32'd2);
    check("mult_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'h0);
    run_check("multu_ffx2", 2'b00, 32'hFFFF_FFFF, 32'd2);
    check("multu_const", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    run_check("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
    check("div_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_check("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu_by0", 2'b10, 32'd7, 32'd0);
    run_check("div_by0", 2'b11, 32'hFFFF_FFF9, 32'd0);

    // Flush mid-operation leaves preloaded HI/LO alone.
    hi_we_i = 1'b1;
    wdata_i = 32'hAA;
    @(negedge clk);
    hi_we_i = 1'b0;
    lo_we_i = 1'b1;
    wdata_i = 32'hBB;
    @(negedge clk);
    lo_we_i = 1'b0;
    issue(2'b00, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'h0);
    check("flush_hilo", {hi_o, lo_o}, {32'hAA, 32'hBB});
    dcnt = 0;
    repeat (40) begin
      if (done_o) dcnt++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dcnt), 64'h0);

    // start and MTHI mid-operation are ignored.
    issue(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    start_i = 1'b1;
    op_i = 2'b11;
    rs_i = 32'd100;
    rt_i = 32'd7;
    hi_we_i = 1'b1;
    wdata_i = 32'hDEAD;
    @(negedge clk);
    start_i = 1'b0;
    hi_we_i = 1'b0;
    check("busy_mthi_ignored", 64'(hi_o), 64'hAA);
    wait_done(cyc, bcnt);
    check("ignore_latency", 64'(cyc), 64'(W + 1 - 6));
    check("ignore_hilo", {hi_o, lo_o}, 64'd15);

    // Back-to-back start in the done cycle.
    run_check("b2b_divu", 2'b10, 32'd15, 32'd4);
    check("b2b_const", {hi_o, lo_o}, {32'd3, 32'd3});

    // Reset mid-DIVU.
    issue(2'b10, 32'd15, 32'd4);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy_o), 64'h0);
    check("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_done", 64'(done_o), 64'h0);

    // IDLE write coincident with start: write lands, then result overwrites.
    hi_we_i = 1'b1;
    wdata_i = 32'hCAFE;
    issue(2'b00, 32'd7, 32'd9);
    hi_we_i = 1'b0;
    check("start_write_hi", 64'(hi_o), 64'hCAFE);
    check("start_write_busy", 64'(busy_o), 64'h1);
    wait_done(cyc, bcnt);
    check("start_write_result", {hi_o, lo_o}, 64'd63);

    // Flush beats start in IDLE but does not block MTLO.
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    lo_we_i = 1'b1;
    wdata_i = 32'h55;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    lo_we_i = 1'b0;
    check("flush_start_busy", 64'(busy_o), 64'h0);
    check("flush_mtlo", 64'(lo_o), 64'h55);
    @(negedge clk);
    check("flush_start_busy2", 64'(busy_o), 64'h0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: b = $urandom_range(1, 20);
        default: ;
      endcase
      run_check("random", op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, executing MULT/MULTU/DIV/DIVU for the pipelined CPU.
- Sits beside the ALU in EX. Hazard detection holds the pipeline while busy_o is high.
- Provides register-file-style HI/LO write access for MTHI/MTLO and read access for MFHI/MFLO.
- Radix-2 sequential datapath: one bit per clock.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  begin operation; sampled only in IDLE
- op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i
- rs_i  in  WIDTH  multiplicand / dividend; sampled with start_i
- rt_i  in  WIDTH  multiplier / divisor; sampled with start_i
- flush_i  in  1  abort any in-progress operation
- hi_we_i  in  1  MTHI write enable
- lo_we_i  in  1  MTLO write enable
- wdata_i  in  WIDTH  MTHI/MTLO write data
- busy_o  out  1  operation in progress; pipeline must stall MF*/MT*/muldiv ops
- done_o  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi_o  out  WIDTH  HI register (product upper half / remainder)
- lo_o  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, any state): state IDLE, hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0, iteration counter = 0. A reset during an operation aborts it and discards the partial result.
- States:
  - IDLE: busy_o = 0.
  - RUN: WIDTH cycles, one bit per cycle.
  - FIX: 1 cycle; sign correction and special cases.
- Transitions: IDLE→RUN on start_i & !flush_i; RUN→FIX when the counter reaches WIDTH-1; FIX→IDLE always.
- Latency: start_i sampled at edge k. busy_o = 1 from after edge k through edge k+WIDTH+1. HI/LO are written at edge k+WIDTH+1, and done_o = 1 for exactly the following cycle. Back-to-back: start_i may be asserted in that done_o cycle.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at start and the unsigned algorithm is run.
  - In FIX: product is negated if the operand signs differ; quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Multiply: 2·WIDTH-bit product; HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide (restoring): LO = quotient, HI = remainder.
- Division by zero (DIV and DIVU): LO = all ones, HI = rs_i as sampled. No exception is raised.
- Signed overflow (most-negative / -1): LO = most-negative value, HI = 0.
- Ignored inputs:
  - start_i while not IDLE: ignored; operands are not resampled.
  - hi_we_i / lo_we_i while busy_o = 1: ignored.
- IDLE writes: hi_we_i / lo_we_i write wdata_i at the edge. If start_i is asserted in the same cycle, the write takes effect and the operation also starts; the operation's result later overwrites both registers.
- flush_i:
  - From RUN or FIX: returns to IDLE at the next edge; HI/LO unchanged; no done_o.
  - In IDLE with start_i also high: flush wins and no operation starts.
  - Does not block hi_we_i / lo_we_i in IDLE.
- hi_o / lo_o are driven directly from registers, with no combinational path from inputs.

Test Plan:
- Reset values: assert rst for 2 cycles, then release → hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0. Then MTHI 0x12345678 → hi_o = 0x12345678 one edge later.
- Multiply (WIDTH = 32):
  - MULT rs = 0xFFFFFFFF, rt = 2 → busy_o high for 33 cycles; done_o pulses 34 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
  - MULTU with the same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- Signed divide:
  - DIV rs = 0xFFFFFFF9 (-7), rt = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Divide by zero: DIVU rs = 7, rt = 0 → lo = 0xFFFFFFFF, hi = 7. DIV rs = 0xFFFFFFF9, rt = 0 → lo = 0xFFFFFFFF, hi = 0xFFFFFFF9.
- Abort and ignore rules:
  - Preload HI = 0xAA, LO = 0xBB. Start MULTU 3×5, assert flush_i at cycle 10 → busy_o low next cycle, no done_o, HI/LO stay 0xAA/0xBB.
  - start_i and hi_we_i pulsed mid-operation → ignored.
- Back-to-back and reset: MULTU 3×5 → lo = 15, hi = 0. Start DIVU 15/4 in the done_o cycle → lo = 3, hi = 3. Assert rst mid-DIVU → immediate IDLE, HI/LO = 0.
